// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the video bank slot arbiter.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISP_RD,
    CPU_RD,
    CPU_WR
  } arb_state_t;

  typedef logic [1:0] grant_t;

  localparam grant_t GNT_NONE = 2'd0;
  localparam grant_t GNT_DISP = 2'd1;
  localparam grant_t GNT_CPU  = 2'd2;

  localparam int DEFAULT_MAX_WAIT = 8;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive slots the CPU lost to the display fetch.
module arb_starve_ctr
  import vram_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] count;

  assign hit = (count == LIMIT);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !hit) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/vram_slot_arbiter.sv
// Single-port video bank arbiter: display fetch vs Z80 access with a starvation guard.
// Optional VRAM_ARB_STATS_EN adds stat_wait/stat_miss counters and a stat_clr input.
module vram_slot_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW       = 14,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_a,
  output logic [7:0]    disp_do,
  output logic          disp_valid,
  output logic          disp_miss,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_di,
  output logic [7:0]    cpu_do,
  output logic          cpu_ack,
  output logic          wait_n,
  output logic [AW-1:0] ram_a,
  output logic          ram_we,
  output logic [7:0]    ram_di,
  input  logic [7:0]    ram_do
`ifdef VRAM_ARB_STATS_EN
  ,
  input  logic          stat_clr,
  output logic [15:0]   stat_wait,
  output logic [15:0]   stat_miss
`endif
);

  arb_state_t state, state_next;
  grant_t     grant;
  logic       done, cpu_pend, starve_hit, forced;
  logic [7:0] disp_q, cpu_q;

  assign cpu_pend = cpu_req & ~done;

  arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clock (clock),
    .reset (reset),
    .inc   ((grant == GNT_DISP) & cpu_pend),
    .clr   ((grant == GNT_CPU) | ~cpu_pend),
    .hit   (starve_hit)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    grant      = GNT_NONE;
    forced     = 1'b0;
    state_next = IDLE;
    if (ce) begin
      if (cpu_pend && starve_hit) begin
        grant  = GNT_CPU;
        forced = disp_req;
      end else if (disp_req) begin
        grant = GNT_DISP;
      end else if (cpu_pend) begin
        grant = GNT_CPU;
      end
    end
    if (grant == GNT_CPU) begin
      state_next = cpu_wr ? CPU_WR : CPU_RD;
    end else if (grant == GNT_DISP) begin
      state_next = DISP_RD;
    end
  end

  // RAM side is driven straight from the grant so the access lands in the slot cycle.
  assign ram_a  = (grant == GNT_CPU) ? cpu_a : disp_a;
  assign ram_we = (grant == GNT_CPU) & cpu_wr & reset;
  assign ram_di = cpu_di;

  assign wait_n     = ~cpu_pend | ~reset;
  assign disp_valid = (state == DISP_RD);
  assign cpu_ack    = (state == CPU_RD) || (state == CPU_WR);

  // Read data is passed through in the completion cycle and held afterwards.
  assign disp_do = (state == DISP_RD) ? ram_do : disp_q;
  assign cpu_do  = (state == CPU_RD)  ? ram_do : cpu_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      disp_q    <= 8'h00;
      cpu_q     <= 8'hFF;
      disp_miss <= 1'b0;
    end else begin
      state     <= state_next;
      disp_miss <= forced;
      if (grant == GNT_CPU) begin
        done <= 1'b1;
      end else if (!cpu_req) begin
        done <= 1'b0;
      end
      if (state == DISP_RD) disp_q <= ram_do;
      if (state == CPU_RD)  cpu_q  <= ram_do;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_wait <= '0;
      stat_miss <= '0;
    end else if (stat_clr) begin
      stat_wait <= '0;
      stat_miss <= '0;
    end else begin
      if (ce && cpu_pend && (grant != GNT_CPU) && (stat_wait != 16'hFFFF)) begin
        stat_wait <= stat_wait + 16'd1;
      end
      if (disp_miss && (stat_miss != 16'hFFFF)) begin
        stat_miss <= stat_miss + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Scoreboard bench: a slot-level reference model queues expected completions, a monitor checks them.
module tb_vram_slot_arbiter;
  import vram_arb_pkg::*;

  localparam int AW       = 14;
  localparam int MAX_WAIT = 8;
  localparam int DEPTH    = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ce = 1'b0, disp_req = 1'b0, cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [AW-1:0] disp_a = '0, cpu_a = '0;
  logic [7:0]    cpu_di = '0;
  logic [7:0]    disp_do, cpu_do, ram_di, ram_do;
  logic [AW-1:0] ram_a;
  logic          disp_valid, disp_miss, cpu_ack, wait_n, ram_we;
`ifdef VRAM_ARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_wait, stat_miss;
`endif

  vram_slot_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) u_dut (
    .clock(clock), .reset(reset), .ce(ce),
    .disp_req(disp_req), .disp_a(disp_a), .disp_do(disp_do),
    .disp_valid(disp_valid), .disp_miss(disp_miss),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_di(cpu_di),
    .cpu_do(cpu_do), .cpu_ack(cpu_ack), .wait_n(wait_n),
    .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
`ifdef VRAM_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_wait(stat_wait), .stat_miss(stat_miss)
`endif
  );

  always #5 clock = ~clock;

  // Bank RAM: synchronous single port, read data valid the cycle after the slot.
  logic [7:0] mem [0:DEPTH-1];
  always @(posedge clock) begin
    if (ram_we) mem[ram_a] <= ram_di;
    ram_do <= mem[ram_a];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       rd;
  } exp_t;

  exp_t exp_disp[$];
  exp_t exp_cpu[$];
  int   exp_miss[$];
  exp_t mon_e;
  int   mon_d;

  // Reference model: who owns each slot, from the arbitration rules.
  logic [7:0] ref_mem [0:DEPTH-1];
  int denials = 0;
  bit m_done = 1'b0;
  int m_wait = 0;
  int m_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event absent or unexpected (cycle %0d)", name, cyc);
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      while (exp_disp.size() > 0 && exp_disp[0].due < cyc) begin
        fail("disp_valid_missing");
        void'(exp_disp.pop_front());
      end
      while (exp_cpu.size() > 0 && exp_cpu[0].due < cyc) begin
        fail("cpu_ack_missing");
        void'(exp_cpu.pop_front());
      end
      while (exp_miss.size() > 0 && exp_miss[0] < cyc) begin
        fail("disp_miss_missing");
        void'(exp_miss.pop_front());
      end
      if (disp_valid) begin
        if (exp_disp.size() == 0) fail("disp_valid_unexpected");
        else begin
          mon_e = exp_disp.pop_front();
          check("disp_valid_time", cyc, mon_e.due);
          check("disp_do", disp_do, mon_e.data);
        end
      end
      if (cpu_ack) begin
        if (exp_cpu.size() == 0) fail("cpu_ack_unexpected");
        else begin
          mon_e = exp_cpu.pop_front();
          check("cpu_ack_time", cyc, mon_e.due);
          if (mon_e.rd) check("cpu_do", cpu_do, mon_e.data);
        end
      end
      if (disp_miss) begin
        if (exp_miss.size() == 0) fail("disp_miss_unexpected");
        else begin
          mon_d = exp_miss.pop_front();
          check("disp_miss_time", cyc, mon_d);
        end
      end
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, 63));
  endfunction

  // Called just after a rising edge with inputs set; predicts this slot and advances one clock.
  task automatic step();
    bit pend, g_cpu, g_disp, miss;
    #1;
    pend   = cpu_req && !m_done;
    g_cpu  = 1'b0;
    g_disp = 1'b0;
    miss   = 1'b0;
    check("wait_n", wait_n, !pend);
    if (ce) begin
      if (pend && denials == MAX_WAIT) begin
        g_cpu = 1'b1;
        miss  = disp_req;
      end else if (disp_req) begin
        g_disp = 1'b1;
        if (pend && denials < MAX_WAIT) denials++;
      end else if (pend) begin
        g_cpu = 1'b1;
      end
      if (pend && !g_cpu) m_wait++;
      check("ram_a", ram_a, g_cpu ? cpu_a : disp_a);
    end
    check("ram_we", ram_we, g_cpu && cpu_wr);
    if (g_cpu && cpu_wr) check("ram_di", ram_di, cpu_di);
    if (miss) begin
      m_miss++;
      exp_miss.push_back(cyc + 1);
    end
    if (g_disp) exp_disp.push_back('{cyc + 1, ref_mem[disp_a], 1'b1});
    if (g_cpu) begin
      exp_cpu.push_back('{cyc + 1, ref_mem[cpu_a], !cpu_wr});
      if (cpu_wr) ref_mem[cpu_a] = cpu_di;
      m_done = 1'b1;
    end else if (!cpu_req) begin
      m_done = 1'b0;
    end
    if (g_cpu || !pend) denials = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_set(input logic wr, input logic [AW-1:0] a, input logic [7:0] di);
    cpu_req = 1'b1;
    cpu_wr  = wr;
    cpu_a   = a;
    cpu_di  = di;
  endtask

  task automatic idle(input int n);
    ce = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_cycle(input int ce_pct, input int disp_pct);
    ce       = ($urandom_range(0, 99) < ce_pct);
    disp_req = ($urandom_range(0, 99) < disp_pct);
    disp_a   = rand_addr();
    if (!cpu_req) begin
      if ($urandom_range(0, 2) == 0) cpu_set(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
    end else if (m_done) begin
      if ($urandom_range(0, 1) == 0) cpu_req = 1'b0;
    end else if ($urandom_range(0, 39) == 0) begin
      cpu_req = 1'b0;
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[14'h0123]     = 8'hA5;
    ref_mem[14'h0123] = 8'hA5;

    // Reset state, with a CPU write request pending to prove nothing escapes.
    ce = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b1; cpu_a = 14'h0005;
    repeat (2) @(posedge clock);
    #1;
    check("rst_disp_do", disp_do, 8'h00);
    check("rst_cpu_do", cpu_do, 8'hFF);
    check("rst_disp_valid", disp_valid, 1'b0);
    check("rst_disp_miss", disp_miss, 1'b0);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_wait_n", wait_n, 1'b1);
`ifdef VRAM_ARB_STATS_EN
    check("rst_stat_wait", stat_wait, 16'd0);
    check("rst_stat_miss", stat_miss, 16'd0);
`endif
    ce = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    idle(1);

    // Idle CPU read.
    ce = 1'b1; disp_req = 1'b0; disp_a = 14'h0040;
    cpu_set(1'b0, 14'h0123, 8'h00);
    step();
    check("rd_ack", cpu_ack, 1'b1);
    check("rd_data", cpu_do, 8'hA5);
    check("rd_wait_n", wait_n, 1'b1);
    idle(1);

    // CPU write, then read back.
    ce = 1'b1;
    cpu_set(1'b1, 14'h2000, 8'h3C);
    step();
    check("wr_ack", cpu_ack, 1'b1);
    idle(1);
    ce = 1'b1;
    cpu_set(1'b0, 14'h2000, 8'h00);
    step();
    check("wr_readback", cpu_do, 8'h3C);
    idle(1);

    // Contention: display every slot, CPU forced through after MAX_WAIT denials.
    ce = 1'b1; disp_req = 1'b1; disp_a = 14'h0010;
    cpu_set(1'b0, 14'h0020, 8'h00);
    for (int i = 0; i < MAX_WAIT; i++) step();
    step();
    check("starve_miss", disp_miss, 1'b1);
    check("starve_ack", cpu_ack, 1'b1);
    check("starve_cleared", u_dut.u_starve.count, 8'd0);
    // Handshake: cpu_req held after ack must not start a second access.
    for (int i = 0; i < 4; i++) begin
      disp_req = (i < 2);
      step();
      check("hold_wait_n", wait_n, 1'b1);
    end
    cpu_req = 1'b0;
    step();
    cpu_set(1'b0, 14'h0021, 8'h00);
    disp_req = 1'b0;
    step();
    check("reissue_ack", cpu_ack, 1'b1);
    idle(1);

    // Back-to-back slots alternating display and CPU.
    ce = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        disp_req = 1'b1; disp_a = rand_addr(); cpu_req = 1'b0;
      end else begin
        disp_req = 1'b0;
        cpu_set(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
      end
      step();
    end
    idle(2);

    // Randomized traffic, then a saturated phase that keeps the guard busy.
    for (int i = 0; i < 1500; i++) rand_cycle(70, 50);
    for (int i = 0; i < 600; i++) rand_cycle(100, 90);
    for (int i = 0; i < 400; i++) rand_cycle(100, 50);
    idle(2);

`ifdef VRAM_ARB_STATS_EN
    check("stat_wait", stat_wait, (m_wait > 65535) ? 65535 : m_wait);
    check("stat_miss", stat_miss, (m_miss > 65535) ? 65535 : m_miss);
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    check("stat_clr_wait", stat_wait, 16'd0);
    check("stat_clr_miss", stat_miss, 16'd0);
`endif

    // Reset during the completion cycle of a CPU read aborts it.
    ce = 1'b1; disp_req = 1'b0;
    cpu_set(1'b0, 14'h0123, 8'h00);
    step();
    reset = 1'b0;
    exp_disp.delete();
    exp_cpu.delete();
    exp_miss.delete();
    denials = 0;
    m_done  = 1'b0;
    #1;
    check("rstmid_ack", cpu_ack, 1'b0);
    check("rstmid_cpu_do", cpu_do, 8'hFF);
    check("rstmid_wait_n", wait_n, 1'b1);
`ifdef VRAM_ARB_STATS_EN
    check("rstmid_stat_wait", stat_wait, 16'd0);
`endif
    @(posedge clock);
    #1;
    check("rstmid_ack_later", cpu_ack, 1'b0);
    cpu_req = 1'b0; ce = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    idle(3);

    if (exp_disp.size() != 0) fail("disp_left_pending");
    if (exp_cpu.size() != 0) fail("cpu_left_pending");
    if (exp_miss.size() != 0) fail("miss_left_pending");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
